joy_update_ctrl: RTL and testbench
==================================

JOY_UPDATE_CTRL -- requirements
Module: joy_update_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CLK_DIV, 50: clk cycles per SCLK half-period.
- SS_SETUP, 1500: clk cycles from ss falling to the first SCLK edge.
- INTERBYTE, 1000: clk cycles of gap between bytes.
- FRAME_CYCLES, 2000000: clk cycles between poll starts.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- clr_n, in, 1: reset, asynchronous, active-low.
- led, in, 2: joystick LED command bits.
- miso, in, 1: PmodJSTK serial data.
- ss, out, 1: slave select, active-low.
- sclk, out, 1: SPI clock.
- mosi, out, 1: serial command.
- joy_x, out, 10: X position.
- joy_y, out, 10: Y position.
- btn, out, 3: buttons.
- upd, out, 1: one-cycle pulse marking new joystick data.
- busy, out, 1: transaction in progress.
- overrun, out, 1: one-cycle pulse when a tick is lost.

Function
REQ-003 A free-running frame counter SHALL count 0..FRAME_CYCLES-1 and wrap; each wrap SHALL set a single pending flag.
REQ-004 The FSM states SHALL be IDLE, SETUP, SHIFT, GAP, DONE.
REQ-005 IDLE with pending set SHALL go to SETUP, clear pending, drive ss=0 and set busy=1 on the same edge.
REQ-006 SETUP SHALL last exactly SS_SETUP cycles and then go to SHIFT with bit index 7 and byte index 0.
REQ-007 SHIFT SHALL use SPI mode 0, MSB first:
- Each bit lasts 2*CLK_DIV cycles.
- sclk is low for the first half and high for the second.
- miso is sampled on the sclk rising edge.
- mosi changes only while sclk is low.
REQ-008 The mosi byte SHALL be {6'b100000, led} for byte 0, with led captured on entry to SETUP, and 8'h00 for bytes 1-4.
REQ-009 After bit 0 of bytes 0-3, the FSM SHALL go to GAP with sclk=0 and ss=0, wait INTERBYTE cycles, then return to SHIFT with the next byte index.
REQ-010 After bit 0 of byte 4, the FSM SHALL go to DONE.
REQ-011 DONE SHALL last 1 cycle and SHALL:
- drive ss=1;
- load joy_x={b1[1:0],b0}, joy_y={b3[1:0],b2}, btn=b4[2:0];
- pulse upd=1 for one cycle;
- go to IDLE with busy=0.
REQ-012 joy_x, joy_y and btn SHALL change only in DONE; no partial values are visible.
REQ-013 A frame wrap while pending is already set SHALL pulse overrun and leave pending set; no queueing beyond one.
REQ-014 A frame wrap during a transaction SHALL set pending, so the next transaction starts the cycle after IDLE is re-entered.
REQ-015 The byte and bit counters SHALL be 3 bits wide; each counter SHALL be cleared on entry to SETUP.
REQ-016 The half-period counter SHALL hold clog2(CLK_DIV) bits and reload on every sclk toggle.

Reset
REQ-017 clr_n=0 SHALL asynchronously force:
- FSM to IDLE, frame counter 0, pending 0;
- ss=1, sclk=0, mosi=0;
- joy_x=512, joy_y=512 (center, so the cursor is stationary), btn=0;
- upd=0, busy=0, overrun=0.
REQ-018 Reset asserted mid-transaction SHALL raise ss within the same cycle and discard all partial bytes.
REQ-019 After clr_n deasserts, the first poll SHALL start after FRAME_CYCLES cycles.

Structure
REQ-020 Package joy_pkg SHALL hold:
- the FSM state enum;
- the byte-count constant 5;
- the command prefix 6'b100000;
- the center constant 10'd512.
REQ-021 Sub-module spi_byte_shifter SHALL contain the 8-bit shift, sclk generation and bit counter, with start and done handshake to the FSM.

Verification (CLK_DIV=2, SS_SETUP=4, INTERBYTE=4, FRAME_CYCLES=400)
REQ-022 Model returns bytes 8'h34,8'h02,8'hC8,8'h01,8'h05 -> joy_x=10'h234, joy_y=10'h1C8, btn=3'b101, one upd pulse, ss low 181 cycles.
REQ-023 led=2'b11 -> byte 0 on mosi = 8'h83; bytes 1-4 = 8'h00; mosi is stable whenever sclk is high.
REQ-024 Reset -> joy_x=joy_y=512; clr_n low at cycle 60 of a transaction -> ss=1 in the same cycle, outputs stay 512, no upd pulse.
REQ-025 FRAME_CYCLES=150, transaction length 181 -> every transaction starts immediately after the previous DONE, and overrun pulses on the frame wraps that find pending already set.
REQ-026 Miso held 1 for all bytes -> joy_x=joy_y=10'h3FF, btn=3'b111; joy_x and joy_y hold their old values while busy=1.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared types and constants for the PmodJSTK poll controller.
package joy_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    DONE
  } state_e;

  // Bytes exchanged per poll: command/X-low, X-high, Y-low, Y-high, buttons.
  localparam int unsigned NUM_BYTES = 5;

  // Upper six bits of the first command byte; the LED bits fill the rest.
  localparam logic [5:0] CMD_PREFIX = 6'b100000;

  // Mid-scale position, so the cursor is stationary until real data arrives.
  localparam logic [9:0] JOY_CENTER = 10'd512;

endpackage

// File: rtl/spi_byte_shifter.sv
// One SPI mode-0 byte transfer, MSB first: generates sclk, shifts mosi out
// and samples miso on every sclk rising edge. done_o is high during the last
// cycle of the transfer, so the caller can move on with no idle cycle.
module spi_byte_shifter #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       clear_i,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       done_o,
  output logic [7:0] rx_byte_o
);

  localparam int            HW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_DIV - 1);

  logic          active_q, active_d;
  logic          sclk_q,   sclk_d;
  logic [7:0]    tx_q,     tx_d;
  logic [7:0]    rx_q,     rx_d;
  logic [2:0]    bit_q,    bit_d;
  logic [HW-1:0] half_q,   half_d;
  logic          half_end;

  assign half_end  = active_q && (half_q == '0);
  assign done_o    = half_end && sclk_q && (bit_q == 3'd0);
  assign sclk_o    = sclk_q;
  assign mosi_o    = tx_q[7];
  assign rx_byte_o = rx_q;

  // Next-state: load on start, toggle sclk at each half-period end, shift on falling edge.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    active_d = active_q;
    sclk_d   = sclk_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    bit_d    = bit_q;
    half_d   = half_q;

    if (clear_i) begin
      bit_d = '0;
      rx_d  = '0;
    end

    if (start_i) begin
      active_d = 1'b1;
      sclk_d   = 1'b0;
      tx_d     = tx_byte_i;
      bit_d    = 3'd7;
      half_d   = HALF_RELOAD;
    end else if (half_end) begin
      half_d = HALF_RELOAD;
      if (!sclk_q) begin
        // Rising edge: capture the slave's bit.
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], miso_i};
      end else begin
        // Falling edge: mosi advances together with sclk going low.
        sclk_d = 1'b0;
        if (bit_q == 3'd0) begin
          active_d = 1'b0;
        end else begin
          bit_d = bit_q - 3'd1;
          tx_d  = {tx_q[6:0], 1'b0};
        end
      end
    end else if (active_q) begin
      half_d = half_q - 1'b1;
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!clr_n) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      bit_q    <= '0;
      half_q   <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      half_q   <= half_d;
    end
  end

endmodule

// File: rtl/joy_update_ctrl.sv
// Periodic PmodJSTK poll: a frame counter raises a pending request, the FSM
// runs a five-byte SPI exchange and publishes position/buttons atomically.
module joy_update_ctrl
  import joy_pkg::*;
#(
  parameter int CLK_DIV      = 50,
  parameter int SS_SETUP     = 1500,
  parameter int INTERBYTE    = 1000,
  parameter int FRAME_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] led,
  input  logic       miso,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  output logic [9:0] joy_x,
  output logic [9:0] joy_y,
  output logic [2:0] btn,
  output logic       upd,
  output logic       busy,
  output logic       overrun
);

  localparam int            FW           = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [FW-1:0] FRAME_LAST   = FW'(FRAME_CYCLES - 1);
  localparam int            WAIT_MAX     = (SS_SETUP > INTERBYTE) ? SS_SETUP : INTERBYTE;
  localparam int            WW           = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] SETUP_RELOAD = WW'(SS_SETUP - 1);
  localparam logic [WW-1:0] GAP_RELOAD   = WW'(INTERBYTE - 1);
  localparam logic [2:0]    LAST_BYTE    = 3'(NUM_BYTES - 1);

  state_e        state_q,   state_d;
  logic [FW-1:0] frame_q,   frame_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic [WW-1:0] wait_q,    wait_d;
  logic [2:0]    byte_q,    byte_d;
  logic [1:0]    led_q,     led_d;
  logic          ss_q,      ss_d;
  logic          busy_q,    busy_d;
  logic          upd_q,     upd_d;
  logic [9:0]    joy_x_q,   joy_x_d;
  logic [9:0]    joy_y_q,   joy_y_d;
  logic [2:0]    btn_q,     btn_d;
  logic [9:0]    stage_x_q, stage_y_q;

  logic          frame_wrap, consume;
  logic          shift_clear, shift_start, shift_done;
  logic [7:0]    tx_byte, rx_byte;

  assign consume = (state_q == IDLE) && pending_q;

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .clr_n     (clr_n),
    .clear_i   (shift_clear),
    .start_i   (shift_start),
    .tx_byte_i (tx_byte),
    .miso_i    (miso),
    .sclk_o    (sclk),
    .mosi_o    (mosi),
    .done_o    (shift_done),
    .rx_byte_o (rx_byte)
  );

  // Frame counter and single-deep request flag; a wrap that finds it still set is lost.
  always_comb begin
    frame_wrap = (frame_q == FRAME_LAST);
    frame_d    = frame_wrap ? '0 : frame_q + 1'b1;
    pending_d  = (pending_q && !consume) || frame_wrap;
    overrun_d  = frame_wrap && pending_q && !consume;
  end

  // Sequencer next-state and registered outputs.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    byte_d      = byte_q;
    led_d       = led_q;
    ss_d        = ss_q;
    busy_d      = busy_q;
    upd_d       = 1'b0;
    joy_x_d     = joy_x_q;
    joy_y_d     = joy_y_q;
    btn_d       = btn_q;
    shift_clear = 1'b0;
    shift_start = 1'b0;
    // Only byte 0 carries the command; the rest are dummy reads.
    tx_byte     = (state_q == SETUP) ? {CMD_PREFIX, led_q} : 8'h00;

    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d     = SETUP;
          wait_d      = SETUP_RELOAD;
          byte_d      = '0;
          led_d       = led;
          ss_d        = 1'b0;
          busy_d      = 1'b1;
          shift_clear = 1'b1;
        end
      end
      SETUP: begin
        if (wait_q == '0) begin
          state_d     = SHIFT;
          shift_start = 1'b1;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          if (byte_q == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            wait_d  = GAP_RELOAD;
          end
        end
      end
      GAP: begin
        if (wait_q == '0) begin
          state_d     = SHIFT;
          byte_d      = byte_q + 3'd1;
          shift_start = 1'b1;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ss_d    = 1'b1;
        busy_d  = 1'b0;
        upd_d   = 1'b1;
        joy_x_d = stage_x_q;
        joy_y_d = stage_y_q;
        btn_d   = rx_byte[2:0];
      end
      default: state_d = IDLE;
    endcase
  end

  // Collect position bits as each byte completes; outputs see them only in DONE.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: staging storage is reset as well, so an aborted poll leaves no partial bytes behind.
    if (!clr_n) begin
      stage_x_q <= '0;
      stage_y_q <= '0;
    end else if ((state_q == SHIFT) && shift_done) begin
      case (byte_q)
        3'd0:    stage_x_q[7:0] <= rx_byte;
        3'd1:    stage_x_q[9:8] <= rx_byte[1:0];
        3'd2:    stage_y_q[7:0] <= rx_byte;
        3'd3:    stage_y_q[9:8] <= rx_byte[1:0];
        default: ;
      endcase
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      wait_q    <= '0;
      byte_q    <= '0;
      led_q     <= '0;
      ss_q      <= 1'b1;
      busy_q    <= 1'b0;
      upd_q     <= 1'b0;
      joy_x_q   <= JOY_CENTER;
      joy_y_q   <= JOY_CENTER;
      btn_q     <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      wait_q    <= wait_d;
      byte_q    <= byte_d;
      led_q     <= led_d;
      ss_q      <= ss_d;
      busy_q    <= busy_d;
      upd_q     <= upd_d;
      joy_x_q   <= joy_x_d;
      joy_y_q   <= joy_y_d;
      btn_q     <= btn_d;
    end
  end

  assign ss      = ss_q;
  assign busy    = busy_q;
  assign upd     = upd_q;
  assign overrun = overrun_q;
  assign joy_x   = joy_x_q;
  assign joy_y   = joy_y_q;
  assign btn     = btn_q;

endmodule

// File: tb/tb_joy_update_ctrl.sv
// Directed bench for joy_update_ctrl: a behavioural PmodJSTK slave, a table of
// full polls, plus reset-abort and back-to-back/overrun sequences.
module tb_joy_update_ctrl;

  localparam int CLK_DIV   = 2;
  localparam int SS_SETUP  = 4;
  localparam int INTERBYTE = 4;
  localparam int FRAME_A   = 400;
  localparam int FRAME_B   = 150;
  // ss low span: 4 setup + 5*32 shift + 4*4 gap + 1 done.
  localparam int TXN_LEN   = 181;

  logic       clk = 1'b0;
  logic       clr_n, clr_b_n;
  logic [1:0] led;
  logic       miso;
  logic       ss, sclk, mosi, upd, busy, overrun;
  logic [9:0] joy_x, joy_y;
  logic [2:0] btn;

  logic       ss_b, sclk_b, mosi_b, upd_b, busy_b, overrun_b;
  logic [9:0] joy_x_b, joy_y_b;
  logic [2:0] btn_b;

  joy_update_ctrl #(
    .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .INTERBYTE(INTERBYTE), .FRAME_CYCLES(FRAME_A)
  ) u_dut (
    .clk(clk), .clr_n(clr_n), .led(led), .miso(miso), .ss(ss), .sclk(sclk), .mosi(mosi),
    .joy_x(joy_x), .joy_y(joy_y), .btn(btn), .upd(upd), .busy(busy), .overrun(overrun)
  );

  // Second instance with a frame shorter than one poll, for back-to-back/overrun.
  joy_update_ctrl #(
    .CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .INTERBYTE(INTERBYTE), .FRAME_CYCLES(FRAME_B)
  ) u_dut_b (
    .clk(clk), .clr_n(clr_b_n), .led(2'b00), .miso(1'b0), .ss(ss_b), .sclk(sclk_b),
    .mosi(mosi_b), .joy_x(joy_x_b), .joy_y(joy_y_b), .btn(btn_b), .upd(upd_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h want 'h%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [39:0] slv_bits   = '0;
  logic [39:0] mosi_seen  = '0;
  logic [5:0]  bit_idx    = '0;
  logic        sclk_prev  = 1'b0;
  logic        mosi_prev  = 1'b0;
  int          stab_err   = 0;

  // Slave presents the next bit after each sclk rise, so it is stable at the DUT sample.
  assign miso = (bit_idx < 6'd40) ? slv_bits[6'd39 - bit_idx] : 1'b0;

  always @(negedge clk) begin
    if (ss === 1'b1) begin
      bit_idx = '0;
    end else if (sclk === 1'b1 && sclk_prev === 1'b0 && bit_idx < 6'd40) begin
      mosi_seen[6'd39 - bit_idx] = mosi;
      bit_idx = bit_idx + 6'd1;
    end
    if (sclk === 1'b1 && sclk_prev === 1'b1 && mosi !== mosi_prev) stab_err++;
    sclk_prev = sclk;
    mosi_prev = mosi;
  end

  // Waits for one poll from the current negedge; collects timing and hold observations.
  task automatic run_txn(input logic [1:0] led_mid, output int wait_cycles, output int low_cycles,
                         output int upd_cnt, output int hold_err, output bit timed_out);
    int guard;
    logic [9:0] x0, y0;
    logic [2:0] b0;
    guard = 0; low_cycles = 0; upd_cnt = 0; hold_err = 0; timed_out = 1'b0;
    x0 = joy_x; y0 = joy_y; b0 = btn;
    while (ss === 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (upd === 1'b1) upd_cnt++;
    end
    wait_cycles = guard;
    if (ss !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    led = led_mid;
    while (ss === 1'b0 && guard < 2000) begin
      low_cycles++;
      if (busy !== 1'b1 || joy_x !== x0 || joy_y !== y0 || btn !== b0 || upd !== 1'b0)
        hold_err++;
      @(negedge clk);
      guard++;
    end
    if (ss !== 1'b1) timed_out = 1'b1;
    if (upd === 1'b1) upd_cnt++;
  endtask

  typedef struct {
    logic [1:0]  led;
    logic [39:0] bytes;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  btn;
    logic [7:0]  cmd;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int wait_c, low_c, upd_c, hold_c, n, rises, first_fall, gap, gap_bad, ovr;
    bit to;
    logic prev_ss;

    vecs[0] = '{led: 2'b00, bytes: 40'h34_02_C8_01_05, x: 10'h234, y: 10'h1C8, btn: 3'b101, cmd: 8'h80};
    vecs[1] = '{led: 2'b11, bytes: 40'hFF_FF_FF_FF_FF, x: 10'h3FF, y: 10'h3FF, btn: 3'b111, cmd: 8'h83};
    vecs[2] = '{led: 2'b01, bytes: 40'h00_00_00_00_00, x: 10'h000, y: 10'h000, btn: 3'b000, cmd: 8'h81};
    vecs[3] = '{led: 2'b10, bytes: 40'hA5_FE_5A_03_FA, x: 10'h2A5, y: 10'h35A, btn: 3'b010, cmd: 8'h82};

    clr_n = 1'b0; clr_b_n = 1'b0; led = 2'b00;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_ss", ss, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_joy_x", joy_x, 10'd512);
    check("rst_joy_y", joy_y, 10'd512);
    check("rst_btn", btn, 3'b000);
    check("rst_upd", upd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    clr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      led      = vecs[i].led;
      slv_bits = vecs[i].bytes;
      run_txn(~vecs[i].led, wait_c, low_c, upd_c, hold_c, to);
      check($sformatf("v%0d_timeout", i), to, 1'b0);
      // Wrap lands on edge FRAME_A, ss drops on the following edge.
      if (i == 0) check("first_poll_delay", wait_c, FRAME_A + 1);
      check($sformatf("v%0d_ss_low", i), low_c, TXN_LEN);
      check($sformatf("v%0d_hold", i), hold_c, 0);
      check($sformatf("v%0d_joy_x", i), joy_x, vecs[i].x);
      check($sformatf("v%0d_joy_y", i), joy_y, vecs[i].y);
      check($sformatf("v%0d_btn", i), btn, vecs[i].btn);
      check($sformatf("v%0d_mosi", i), mosi_seen, {vecs[i].cmd, 32'h0});
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
      @(negedge clk);
      if (upd === 1'b1) upd_c++;
      check($sformatf("v%0d_upd_pulses", i), upd_c, 1);
    end
    check("mosi_stable_sclk_high", stab_err, 0);

    // Abort a poll at its 60th ss-low cycle.
    slv_bits = 40'h11_01_22_02_03;
    n = 0;
    while (ss === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_ss_fell", ss, 1'b0);
    repeat (59) @(negedge clk);
    #1 clr_n = 1'b0;
    #1;
    check("abort_ss", ss, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_joy_x", joy_x, 10'd512);
    check("abort_joy_y", joy_y, 10'd512);
    check("abort_btn", btn, 3'b000);
    check("abort_upd", upd, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    upd_c = 0; low_c = 0; hold_c = 0;
    repeat (300) begin
      @(negedge clk);
      if (upd === 1'b1) upd_c++;
      if (ss !== 1'b1) low_c++;
      if (joy_x !== 10'd512 || joy_y !== 10'd512) hold_c++;
    end
    check("post_abort_upd", upd_c, 0);
    check("post_abort_ss", low_c, 0);
    check("post_abort_center", hold_c, 0);

    // Frame shorter than a poll: back-to-back polls, one-deep pending, overruns.
    clr_b_n = 1'b1;
    n = 0; rises = 0; first_fall = -1; gap = 0; gap_bad = 0; ovr = 0; prev_ss = 1'b1;
    while (rises < 10 && n < 2500) begin
      @(negedge clk);
      n++;
      if (overrun_b === 1'b1) ovr++;
      if (ss_b === 1'b0 && prev_ss === 1'b1) begin
        if (first_fall < 0) first_fall = n;
        else if (gap != 1) gap_bad++;
      end
      if (ss_b === 1'b1 && prev_ss === 1'b0) begin
        rises++;
        gap = 0;
      end
      if (ss_b === 1'b1) gap++;
      prev_ss = ss_b;
    end
    check("b2b_polls", rises, 10);
    check("b2b_first_fall", first_fall, FRAME_B + 1);
    check("b2b_gap", gap_bad, 0);
    // Polls start at 151+182k; wraps at 150m; wraps 1050 and 1950 find pending set.
    check("b2b_tenth_done", n, 1970);
    check("b2b_overruns", ovr, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
